// File: rtl/rvnoob_axi_pkg.sv
// Shared definitions for the rvnoob AXI4 master, slave memory and arbiter:
// bridge FSM states plus AXI burst and response encodings.
package rvnoob_axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_XFER = 3'd3,
    ST_WR_RESP = 3'd4
  } axi_state_e;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/rvnoob_axi_master_if.sv
// AXI4 five-channel bundle between the rvnoob master bridge and its slave.
// Handshake: a beat transfers on a rising clock edge where VALID and READY are
// both high; once raised, VALID and its payload hold until that edge.
interface rvnoob_axi_master_if #(
  parameter int ID_W   = 4,
  parameter int DATA_W = 64,
  parameter int ADDR_W = 32
);
  logic              awvalid, awready;
  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;

  logic                wvalid, wready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;

  logic            bvalid, bready;
  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;

  logic              arvalid, arready;
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;

  logic              rvalid, rready;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;

  modport master (
    output awvalid, awid, awaddr, awlen, awsize, awburst, input awready,
    output wvalid, wdata, wstrb, wlast, input wready,
    input  bvalid, bid, bresp, output bready,
    output arvalid, arid, araddr, arlen, arsize, arburst, input arready,
    input  rvalid, rid, rdata, rresp, rlast, output rready
  );

  modport slave (
    input  awvalid, awid, awaddr, awlen, awsize, awburst, output awready,
    input  wvalid, wdata, wstrb, wlast, output wready,
    output bvalid, bid, bresp, input bready,
    input  arvalid, arid, araddr, arlen, arsize, arburst, output arready,
    output rvalid, rid, rdata, rresp, rlast, input rready
  );
endinterface

// File: rtl/rvnoob_axi_master.sv
// Bridges the core request/stream interface to single-outstanding AXI4 INCR
// bursts; beat counting and protocol checking live inline with the FSM.
module rvnoob_axi_master
  import rvnoob_axi_pkg::*;
#(
  parameter int                          C_M_AXI_ID_WIDTH   = 4,
  parameter int                          C_M_AXI_DATA_WIDTH = 64,
  parameter int                          C_M_AXI_ADDR_WIDTH = 32,
  parameter logic [C_M_AXI_ID_WIDTH-1:0] C_M_AXI_ID         = '0
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESETN,
  input  logic                            req_valid_i,
  output logic                            req_ready_o,
  input  logic                            req_write_i,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [7:0]                      req_len_i,
  input  logic [2:0]                      req_size_i,
  input  logic                            wd_valid_i,
  output logic                            wd_ready_o,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   wd_data_i,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] wd_strb_i,
  output logic                            rd_valid_o,
  input  logic                            rd_ready_i,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rd_data_o,
  output logic [1:0]                      rd_resp_o,
  output logic                            rd_last_o,
  output logic                            wr_done_o,
  output logic [1:0]                      wr_resp_o,
  output logic                            proto_err_o,
  output axi_state_e                      state_o,
  rvnoob_axi_master_if.master             m_axi
);

  axi_state_e                    state_q, state_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]                    len_q, len_d;
  logic [7:0]                    cnt_q, cnt_d;
  logic [2:0]                    size_q, size_d;
  logic                          aw_done_q, aw_done_d;
  logic                          w_done_q, w_done_d;
  logic                          wr_done_q, wr_done_d;
  logic [1:0]                    wr_resp_q, wr_resp_d;
  logic                          proto_err_q, proto_err_d;
  logic                          cnt_last, aw_hs, w_hs, r_hs;

  // One counter serves both directions; w_done_q marks the final W beat so
  // len=255 never needs a ninth counter bit.
  assign cnt_last = (cnt_q == len_q);

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      size_q      <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      wr_done_q   <= 1'b0;
      wr_resp_q   <= RESP_OKAY;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      size_q      <= size_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      wr_done_q   <= wr_done_d;
      wr_resp_q   <= wr_resp_d;
      proto_err_q <= proto_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    size_d        = size_q;
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;
    wr_done_d     = 1'b0;
    wr_resp_d     = wr_resp_q;
    proto_err_d   = proto_err_q;
    req_ready_o   = 1'b0;
    rd_valid_o    = 1'b0;
    rd_last_o     = 1'b0;
    wd_ready_o    = 1'b0;
    m_axi.arvalid = 1'b0;
    m_axi.rready  = 1'b0;
    m_axi.awvalid = 1'b0;
    m_axi.wvalid  = 1'b0;
    m_axi.wlast   = 1'b0;
    m_axi.bready  = 1'b0;
    aw_hs         = 1'b0;
    w_hs          = 1'b0;
    r_hs          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        req_ready_o = M_AXI_ARESETN;
        if (req_valid_i) begin
          addr_d    = req_addr_i;
          len_d     = req_len_i;
          size_d    = req_size_i;
          cnt_d     = '0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = req_write_i ? ST_WR_XFER : ST_RD_ADDR;
        end
      end
      ST_RD_ADDR: begin
        m_axi.arvalid = 1'b1;
        if (m_axi.arready) state_d = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        m_axi.rready = rd_ready_i;
        rd_valid_o   = m_axi.rvalid;
        rd_last_o    = cnt_last;
        r_hs         = m_axi.rvalid && rd_ready_i;
        if (r_hs) begin
          // The counter ends the burst; a disagreeing RLAST is only flagged.
          if (m_axi.rlast != cnt_last) proto_err_d = 1'b1;
          if (cnt_last) state_d = ST_IDLE;
          else          cnt_d   = cnt_q + 8'd1;
        end
      end
      ST_WR_XFER: begin
        m_axi.awvalid = !aw_done_q;
        m_axi.wvalid  = wd_valid_i && !w_done_q;
        m_axi.wlast   = cnt_last;
        wd_ready_o    = m_axi.wready && !w_done_q;
        aw_hs         = !aw_done_q && m_axi.awready;
        w_hs          = wd_valid_i && m_axi.wready && !w_done_q;
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs) begin
          if (cnt_last) w_done_d = 1'b1;
          else          cnt_d    = cnt_q + 8'd1;
        end
        if ((aw_done_q || aw_hs) && (w_done_q || (w_hs && cnt_last))) state_d = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        m_axi.bready = 1'b1;
        if (m_axi.bvalid) begin
          wr_done_d = 1'b1;
          wr_resp_d = m_axi.bresp;
          if (m_axi.bid != C_M_AXI_ID) proto_err_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign m_axi.arid    = C_M_AXI_ID;
  assign m_axi.araddr  = addr_q;
  assign m_axi.arlen   = len_q;
  assign m_axi.arsize  = size_q;
  assign m_axi.arburst = BURST_INCR;
  assign m_axi.awid    = C_M_AXI_ID;
  assign m_axi.awaddr  = addr_q;
  assign m_axi.awlen   = len_q;
  assign m_axi.awsize  = size_q;
  assign m_axi.awburst = BURST_INCR;
  assign m_axi.wdata   = wd_data_i;
  assign m_axi.wstrb   = wd_strb_i;

  assign rd_data_o   = m_axi.rdata;
  assign rd_resp_o   = m_axi.rresp;
  assign wr_done_o   = wr_done_q;
  assign wr_resp_o   = wr_resp_q;
  assign proto_err_o = proto_err_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_rvnoob_axi_master.sv
// Directed bench for rvnoob_axi_master with a small AXI slave memory model.
module tb_rvnoob_axi_master;
  import rvnoob_axi_pkg::*;

  localparam int DW = 64;
  localparam int AW = 32;
  localparam int IW = 4;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic            req_valid, req_ready_o, req_write;
  logic [AW-1:0]   req_addr;
  logic [7:0]      req_len;
  logic [2:0]      req_size;
  logic            wd_valid, wd_ready_o;
  logic [DW-1:0]   wd_data;
  logic [DW/8-1:0] wd_strb;
  logic            rd_valid_o, rd_ready, rd_last_o;
  logic [DW-1:0]   rd_data_o;
  logic [1:0]      rd_resp_o, wr_resp_o;
  logic            wr_done_o, proto_err_o;
  axi_state_e      state_o;

  rvnoob_axi_master_if #(.ID_W(IW), .DATA_W(DW), .ADDR_W(AW)) axi ();

  rvnoob_axi_master #(
    .C_M_AXI_ID_WIDTH(IW), .C_M_AXI_DATA_WIDTH(DW), .C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_ID('0)
  ) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_len_i(req_len), .req_size_i(req_size),
    .wd_valid_i(wd_valid), .wd_ready_o(wd_ready_o), .wd_data_i(wd_data), .wd_strb_i(wd_strb),
    .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready), .rd_data_o(rd_data_o),
    .rd_resp_o(rd_resp_o), .rd_last_o(rd_last_o),
    .wr_done_o(wr_done_o), .wr_resp_o(wr_resp_o), .proto_err_o(proto_err_o),
    .state_o(state_o), .m_axi(axi)
  );

  int checks = 0;
  int errors = 0;

  // slave memory model state and knobs
  logic [DW-1:0]   mem [0:63];
  int              cyc = 0;
  int              aw_stall = 0;
  int              bad_rlast_beat = -1;
  logic [IW-1:0]   sl_bid = '0;
  bit              r_active = 0;
  logic [AW-1:0]   r_addr = '0;
  int              r_len = 0, r_beat = 0;
  bit              aw_seen = 0, wl_seen = 0;
  logic [AW-1:0]   w_addr = '0;
  logic [DW-1:0]   wq_data[$];
  logic [DW/8-1:0] wq_strb[$];
  bit              wl_log[$];
  int              aw_hs_cyc = -1, w_last_cyc = -1, wresp_first_cyc = -1;
  bit              bready_at_wresp = 0;
  int              wr_done_cnt = 0, rd_hs_cnt = 0;

  // scoreboard of read beats as seen by the core side
  logic [DW-1:0]   got_data[$];
  bit              got_last[$];
  logic [DW-1:0]   wtx[$];

  function automatic int idx(input logic [AW-1:0] a);
    return int'(a[8:3]);
  endfunction

  function automatic logic [DW-1:0] init_word(input int i);
    return {32'hC0DE_0000 + 32'(i), 32'h1234_0000 + 32'(i)};
  endfunction

  initial begin : slave_model
    logic [AW-1:0] wa;
    for (int i = 0; i < 64; i++) mem[i] = init_word(i);
    axi.arready = 0; axi.rvalid = 0; axi.rid = '0; axi.rdata = '0; axi.rresp = RESP_OKAY;
    axi.rlast = 0; axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bid = '0;
    axi.bresp = RESP_OKAY;
    forever begin
      @(posedge clk);
      cyc++;
      if (state_o == ST_WR_RESP && wresp_first_cyc < 0) begin
        wresp_first_cyc = cyc;
        bready_at_wresp = axi.bready;
      end
      if (wr_done_o) wr_done_cnt++;
      if (rd_valid_o && rd_ready) rd_hs_cnt++;
      if (!rst_n) begin
        r_active = 0; aw_seen = 0; wl_seen = 0;
        wq_data.delete(); wq_strb.delete();
      end else begin
        if (axi.rvalid && axi.rready) begin
          if (r_beat == r_len) r_active = 0;
          else r_beat++;
        end
        if (axi.arvalid && axi.arready) begin
          r_active = 1; r_addr = axi.araddr; r_len = int'(axi.arlen); r_beat = 0;
        end
        if (axi.awvalid && axi.awready) begin
          aw_seen = 1; w_addr = axi.awaddr; aw_hs_cyc = cyc;
        end
        if (axi.wvalid && axi.wready) begin
          wq_data.push_back(axi.wdata); wq_strb.push_back(axi.wstrb); wl_log.push_back(axi.wlast);
          if (axi.wlast) begin wl_seen = 1; w_last_cyc = cyc; end
        end
        if (axi.bvalid && axi.bready) begin
          foreach (wq_data[k]) begin
            wa = w_addr + AW'(k * 8);
            for (int b = 0; b < DW / 8; b++)
              if (wq_strb[k][b]) mem[idx(wa)][b*8 +: 8] = wq_data[k][b*8 +: 8];
          end
          wq_data.delete(); wq_strb.delete();
          aw_seen = 0; wl_seen = 0;
        end
      end
      @(negedge clk);
      axi.arready = rst_n && !r_active;
      axi.rvalid  = r_active;
      axi.rdata   = r_active ? mem[idx(r_addr + AW'(r_beat * 8))] : '0;
      axi.rlast   = r_active && (r_beat == r_len || r_beat == bad_rlast_beat);
      if (axi.awvalid && aw_stall > 0) begin
        axi.awready = 0;
        aw_stall--;
      end else axi.awready = rst_n;
      axi.wready = rst_n;
      axi.bvalid = aw_seen && wl_seen;
      axi.bid    = sl_bid;
    end
  end

  // driver tasks
  task automatic issue_req(input bit wr, input logic [AW-1:0] a, input logic [7:0] l, output bit ok);
    int n = 0;
    @(negedge clk);
    req_valid = 1; req_write = wr; req_addr = a; req_len = l; req_size = 3'd3;
    ok = 0;
    while (!ok && n < 20) begin
      @(posedge clk);
      ok = req_ready_o;
      n++;
    end
    @(negedge clk);
    req_valid = 0;
  endtask

  task automatic collect_reads(input int n, input bit toggle);
    int t = 0;
    got_data.delete(); got_last.delete();
    while (got_data.size() < n && t < 200) begin
      @(negedge clk);
      rd_ready = toggle ? ((t % 2) == 1) : 1'b1;
      @(posedge clk);
      if (rd_valid_o && rd_ready) begin
        got_data.push_back(rd_data_o);
        got_last.push_back(rd_last_o);
      end
      t++;
    end
    @(negedge clk);
    rd_ready = 0;
  endtask

  task automatic send_wbeats(input int delay, input logic [DW/8-1:0] strb, output bit ok);
    int  n;
    bit  hs;
    ok = 1;
    repeat (delay) @(negedge clk);
    foreach (wtx[k]) begin
      wd_valid = 1; wd_data = wtx[k]; wd_strb = strb;
      n = 0; hs = 0;
      while (!hs && n < 30) begin
        @(posedge clk);
        hs = wd_ready_o;
        n++;
      end
      if (!hs) ok = 0;
      @(negedge clk);
    end
    wd_valid = 0;
  endtask

  task automatic wait_wr_done(output bit ok, output logic [1:0] resp);
    int n = 0;
    ok = 0; resp = 2'bxx;
    while (!ok && n < 40) begin
      @(posedge clk);
      if (wr_done_o) begin ok = 1; resp = wr_resp_o; end
      n++;
    end
    @(negedge clk);
  endtask

  // scenarios
  task automatic test_reset();
    #2 rst_n = 0;
    #1;
    checks++;
    if ({req_ready_o, axi.arvalid, axi.awvalid, axi.wvalid, axi.bready, axi.rready,
         rd_valid_o, wd_ready_o, wr_done_o, proto_err_o} !== 10'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 0000000000",
               {req_ready_o, axi.arvalid, axi.awvalid, axi.wvalid, axi.bready, axi.rready,
                rd_valid_o, wd_ready_o, wr_done_o, proto_err_o});
    end
    checks++;
    if ({axi.araddr, axi.awaddr, axi.arlen, axi.awlen, axi.arid, wr_resp_o} !== '0) begin
      errors++;
      $display("FAIL reset_fields: araddr %h arlen %h wr_resp %b required zeros",
               axi.araddr, axi.arlen, wr_resp_o);
    end
    checks++;
    if (state_o !== ST_IDLE) begin
      errors++; $display("FAIL reset_state: got %0d required %0d", state_o, ST_IDLE);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    checks++;
    if (req_ready_o !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: got %b required 1", req_ready_o);
    end
  endtask

  task automatic test_single_read();
    bit ok;
    issue_req(0, 32'h8000_0000, 8'd0, ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL single_accept: got %b required 1", ok); end
    checks++;
    if ({axi.arvalid, axi.arlen, axi.arburst, axi.araddr} !== {1'b1, 8'd0, 2'b01, 32'h8000_0000}) begin
      errors++;
      $display("FAIL single_ar: arvalid %b arlen %h arburst %b araddr %h required 1 00 01 80000000",
               axi.arvalid, axi.arlen, axi.arburst, axi.araddr);
    end
    collect_reads(1, 0);
    checks++;
    if (got_data.size() !== 1 || got_data[0] !== 64'hC0DE0000_12340000 || got_last[0] !== 1'b1) begin
      errors++;
      $display("FAIL single_beat: n %0d data %h last %b required 1 c0de000012340000 1",
               got_data.size(), got_data[0], got_last[0]);
    end
    checks++;
    if (state_o !== ST_IDLE) begin
      errors++; $display("FAIL single_idle: got %0d required %0d", state_o, ST_IDLE);
    end
  endtask

  task automatic test_burst_read();
    bit ok;
    issue_req(0, 32'h8000_0000, 8'd3, ok);
    collect_reads(4, 1);
    checks++;
    if (!ok || got_data.size() != 4) begin
      errors++; $display("FAIL burst_count: accepted %b beats %0d required 1 4", ok, got_data.size());
    end
    foreach (got_data[k]) begin
      checks++;
      if (got_data[k] !== init_word(k) || got_last[k] !== (k == 3)) begin
        errors++;
        $display("FAIL burst_beat%0d: data %h last %b required %h %b",
                 k, got_data[k], got_last[k], init_word(k), (k == 3));
      end
    end
  endtask

  task automatic test_burst_write();
    bit ok, wok, dok;
    logic [1:0] resp;
    wtx = '{64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888};
    wl_log.delete(); wr_done_cnt = 0;
    issue_req(1, 32'h8000_0100, 8'd1, ok);
    send_wbeats(3, 8'h0F, wok);
    wait_wr_done(dok, resp);
    repeat (3) @(negedge clk);
    checks++;
    if (!(ok && wok && dok) || resp !== RESP_OKAY) begin
      errors++; $display("FAIL write_done: acc %b w %b done %b resp %b required 1 1 1 00", ok, wok, dok, resp);
    end
    checks++;
    if (wl_log.size() != 2 || wl_log[0] !== 1'b0 || wl_log[1] !== 1'b1) begin
      errors++; $display("FAIL write_wlast: beats %0d last0 %b last1 %b required 2 0 1",
                         wl_log.size(), wl_log[0], wl_log[1]);
    end
    checks++;
    if (wr_done_cnt != 1) begin
      errors++; $display("FAIL write_done_width: got %0d cycles required 1", wr_done_cnt);
    end
    issue_req(0, 32'h8000_0100, 8'd1, ok);
    collect_reads(2, 0);
    checks++;
    if (got_data.size() != 2 || got_data[0] !== 64'hC0DE0020_33334444 || got_data[1] !== 64'hC0DE0021_77778888) begin
      errors++; $display("FAIL write_readback: got %h %h required c0de002033334444 c0de002177778888",
                         got_data[0], got_data[1]);
    end
  endtask

  task automatic test_w_before_aw();
    bit ok, wok, dok;
    logic [1:0] resp;
    wtx = '{64'hAAAA_0000_0000_0001, 64'hAAAA_0000_0000_0002};
    aw_stall = 5; wresp_first_cyc = -1; aw_hs_cyc = -1; w_last_cyc = -1;
    issue_req(1, 32'h8000_0180, 8'd1, ok);
    send_wbeats(0, 8'hFF, wok);
    wait_wr_done(dok, resp);
    checks++;
    if (!(ok && wok && dok)) begin
      errors++; $display("FAIL waw_done: acc %b w %b done %b required 1 1 1", ok, wok, dok);
    end
    checks++;
    if (!(w_last_cyc > 0 && w_last_cyc < aw_hs_cyc)) begin
      errors++; $display("FAIL waw_order: wlast cycle %0d aw cycle %0d required wlast first", w_last_cyc, aw_hs_cyc);
    end
    checks++;
    if (wresp_first_cyc != aw_hs_cyc + 1 || bready_at_wresp !== 1'b1) begin
      errors++; $display("FAIL waw_wresp: entered %0d bready %b required %0d 1",
                         wresp_first_cyc, bready_at_wresp, aw_hs_cyc + 1);
    end
  endtask

  task automatic test_proto_err();
    bit ok;
    checks++;
    if (proto_err_o !== 1'b0) begin errors++; $display("FAIL perr_before: got %b required 0", proto_err_o); end
    bad_rlast_beat = 1;
    issue_req(0, 32'h8000_0000, 8'd3, ok);
    collect_reads(4, 0);
    bad_rlast_beat = -1;
    checks++;
    if (got_data.size() != 4 || got_data[3] !== init_word(3) || got_last[3] !== 1'b1) begin
      errors++; $display("FAIL perr_beats: n %0d last data %h required 4 %h", got_data.size(), got_data[3], init_word(3));
    end
    checks++;
    if (proto_err_o !== 1'b1) begin errors++; $display("FAIL perr_set: got %b required 1", proto_err_o); end
    repeat (4) @(negedge clk);
    checks++;
    if (proto_err_o !== 1'b1) begin errors++; $display("FAIL perr_sticky: got %b required 1", proto_err_o); end
  endtask

  task automatic test_reset_mid_read();
    bit ok;
    int n = 0, t = 0, hs_snap;
    issue_req(0, 32'h8000_0000, 8'd7, ok);
    rd_ready = 1;
    while (n < 2 && t < 100) begin
      @(posedge clk);
      if (rd_valid_o && rd_ready) n++;
      t++;
    end
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    checks++;
    if (state_o !== ST_IDLE || {rd_valid_o, req_ready_o, axi.arvalid, proto_err_o, wr_done_o} !== 5'b0
        || axi.araddr !== '0 || axi.arlen !== '0) begin
      errors++; $display("FAIL rst_mid: beats %0d state %0d ctl %b araddr %h arlen %h required 2 0 00000 0 0",
                         n, state_o, {rd_valid_o, req_ready_o, axi.arvalid, proto_err_o, wr_done_o},
                         axi.araddr, axi.arlen);
    end
    hs_snap = rd_hs_cnt;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1; rd_ready = 0;
    checks++;
    if (rd_hs_cnt != hs_snap) begin
      errors++; $display("FAIL rst_no_beats: got %0d extra required 0", rd_hs_cnt - hs_snap);
    end
    issue_req(0, 32'h8000_0008, 8'd0, ok);
    collect_reads(1, 0);
    checks++;
    if (!ok || got_data.size() != 1 || got_data[0] !== init_word(1)) begin
      errors++; $display("FAIL rst_resume: acc %b n %0d data %h required 1 1 %h", ok, got_data.size(), got_data[0], init_word(1));
    end
  endtask

  task automatic test_bid_err();
    bit ok, wok, dok;
    logic [1:0] resp;
    checks++;
    if (proto_err_o !== 1'b0) begin errors++; $display("FAIL bid_before: got %b required 0", proto_err_o); end
    wtx = '{64'hBEEF_0000_0000_00C0};
    sl_bid = 4'd1;
    issue_req(1, 32'h8000_01C0, 8'd0, ok);
    send_wbeats(0, 8'hFF, wok);
    wait_wr_done(dok, resp);
    sl_bid = '0;
    checks++;
    if (!(ok && wok && dok) || proto_err_o !== 1'b1) begin
      errors++; $display("FAIL bid_err: done %b proto_err %b required 1 1", dok, proto_err_o);
    end
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    req_valid = 0; req_write = 0; req_addr = '0; req_len = '0; req_size = '0;
    wd_valid = 0; wd_data = '0; wd_strb = '0; rd_ready = 0;
    test_reset();
    test_single_read();
    test_burst_read();
    test_burst_write();
    test_w_before_aw();
    test_proto_err();
    test_reset_mid_read();
    test_bid_err();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
